bcd_stopwatch_ctrl: RTL

- Controller that sequences a 3-digit BCD counter (000-999): start/stop/clear command handling, tick prescaling, and terminal-count handling.
- Contains one combinational bcd_inc instance; the count register feeds its input and its output is the next count.
- Sits between debounced user controls and the seven-segment display driver. Outputs a registered 12-bit BCD value.

---
 rtl/bcd_stopwatch_ctrl.sv | 63 ++++++
 1 files changed

// File: rtl/bcd_stopwatch_ctrl.sv
// bcd_stopwatch_ctrl: start/stop/clear sequenced 3-digit BCD stopwatch with tick prescaler and terminal count
module bcd_inc (
  input  logic [11:0] d,
  output logic [11:0] q
);
  logic c0, c1;
  always_comb begin
    c0 = d[3:0] == 4'd9;
    c1 = c0 && d[7:4] == 4'd9;
    q[3:0] = c0 ? 4'd0 : d[3:0] + 4'd1;
    q[7:4] = c1 ? 4'd0 : c0 ? d[7:4] + 4'd1 : d[7:4];
    q[11:8] = c1 ? (d[11:8] == 4'd9 ? 4'd0 : d[11:8] + 4'd1) : d[11:8];
  end
endmodule

module bcd_stopwatch_ctrl #(
  parameter int TICK_DIV = 100000,
  parameter int WRAP = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic        stop,
  input  logic        clear,
  output logic [11:0] bcd_out,
  output logic        running,
  output logic        tc
);
  localparam int PW = TICK_DIV > 1 ? $clog2(TICK_DIV) : 1;
  localparam logic [PW-1:0] PMAX = PW'(TICK_DIV - 1);
  typedef enum logic [1:0] {IDLE, RUN, PAUSED, DONE} state_t;
  state_t state, state_nxt;
  logic [PW-1:0] psc, psc_nxt;
  logic [11:0] inc, bcd_nxt;
  logic tick, term, tc_nxt;
  bcd_inc u_inc (.d(bcd_out), .q(inc));
  always_comb begin
    tick = state == RUN && psc == PMAX;
    term = tick && bcd_out == 12'h999;
    psc_nxt = clear || tick ? '0 : state == RUN ? psc + PW'(1) : psc;
    bcd_nxt = clear ? 12'h000 : tick && !(term && WRAP == 0) ? inc : bcd_out;
    tc_nxt = term && !clear;
    state_nxt = clear ? IDLE
              : term && WRAP == 0 ? DONE
              : stop && state == RUN ? PAUSED
              : start && (state == IDLE || state == PAUSED) ? RUN
              : state;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      psc <= '0;
      bcd_out <= 12'h000;
      tc <= 1'b0;
    end else begin
      state <= state_nxt;
      psc <= psc_nxt;
      bcd_out <= bcd_nxt;
      tc <= tc_nxt;
    end
  end
  assign running = state == RUN;
endmodule
